regbank_write_scheduler: RTL and testbench
==========================================

// Module: regbank_write_scheduler
// PURPOSE
//  Owns the register_bank write port and the issue-side hazard check. Tracks pending destination
//  registers in a scoreboard, stalls issue on RAW/WAW hazards, and merges two write-back sources
//  (ALU, MEM) into the bank's single write port through a one-entry ALU holding buffer.
//  Sits between decode/issue and the register_bank.
// PARAMETERS
//  NREG  32  number of architectural registers (r0 hard-wired zero)
//  AW    5   register address width, log2(NREG)
//  DW    32  data width
//  CNTW  16  stall counter width
// PORTS
//  clk          in   1     clock; all state on rising edge
//  reset        in   1     synchronous, active-high
//  issue_valid  in   1     decode presents an instruction
//  issue_rs     in   AW    source register A
//  issue_rt     in   AW    source register B
//  issue_rd     in   AW    destination register
//  issue_wr     in   1     instruction writes issue_rd
//  issue_ready  out  1     instruction accepted this cycle when issue_valid & issue_ready
//  alu_wb_valid in   1     ALU write-back request
//  alu_wb_rd    in   AW    ALU destination
//  alu_wb_data  in   DW    ALU result
//  alu_wb_ready out  1     ALU request accepted
//  mem_wb_valid in   1     load write-back request
//  mem_wb_rd    in   AW    load destination
//  mem_wb_data  in   DW    load data
//  mem_wb_ready out  1     load request accepted
//  rf_we        out  1     register_bank write enable (registered)
//  rf_waddr     out  AW    register_bank write address (registered)
//  rf_wdata     out  DW    register_bank write data (registered)
//  pending      out  NREG  scoreboard vector, bit i = write to ri outstanding
//  stall_cnt    out  CNTW  saturating count of cycles with issue_valid & ~issue_ready
// BEHAVIOUR
//  Reset: pending=0, buffer empty, rf_we=0, rf_waddr=0, rf_wdata=0, stall_cnt=0.
//  issue_ready (combinational) = ~pending[rs] & ~pending[rt] & ~(issue_wr & pending[rd]).
//   Check uses registered pending only; a same-cycle commit does not unblock until next cycle.
//  Accepted issue with issue_wr=1 and rd!=0 sets pending[rd] next edge. rd=0 never sets a bit.
//  Write-port arbitration, per cycle, priority order:
//   1. buffer valid: commit buffer; mem_wb_ready=0, alu_wb_ready=0.
//   2. buffer empty, mem_wb_valid: commit MEM; if alu_wb_valid too, ALU captured into buffer.
//   3. buffer empty, only alu_wb_valid: commit ALU directly.
//   Buffer empty: mem_wb_ready=1, alu_wb_ready=1. Buffer full: both ready=0.
//  Commit: rf_we/waddr/wdata registered (write lands in the bank 1 cycle after handshake);
//   pending[rd] cleared on same edge. Commit to r0: handshake completes, rf_we stays 0.
//  Issue set and commit clear hitting the same bit on the same edge: set wins (unreachable
//   under the WAW rule, but defined).
//  Write-back to a register whose pending bit is 0: still written, bit unchanged.
//  stall_cnt saturates at 2^CNTW-1; never wraps.
//  Reset mid-operation: buffered ALU entry discarded, scoreboard cleared, no write issued.
// STRUCTURE
//  regbank_pkg: NREG, AW, DW constants; WB source encoding (WB_ALU=0, WB_MEM=1).
//  One sub-module: wb_hold_buffer (1-entry rd/data register with valid, load/drain).
//  Scoreboard, arbitration and stall counter live in the top.
// TESTING
//  Issue rd=5 wr=1 -> pending[5]=1; next issue rs=5 -> issue_ready=0, stall_cnt increments each cycle.
//  ALU wb rd=5 data=0x1234 -> next cycle rf_we=1 waddr=5 wdata=0x1234, pending[5]=0, stalled issue accepted.
//  MEM rd=3 0xAAAA and ALU rd=4 0xBBBB same cycle -> cycle+1 writes r3, cycle+2 writes r4; ready low in between.
//  Issue rd=0 wr=1 and wb to r0 -> pending stays 0, rf_we stays 0, handshake completes.
//  Hold issue_valid stalled 2^CNTW+10 cycles -> stall_cnt=0xFFFF, no wrap.
//  Reset asserted with buffer full and pending=0x30 -> next cycle all outputs at reset values, no write.

Source files
------------

// File: rtl/regbank_write_scheduler_pkg.sv
// Shared constants and the write-back source encoding used by the write scheduler.
package regbank_write_scheduler_pkg;

  localparam int NREG = 32;   // architectural registers, r0 hard-wired zero
  localparam int AW   = 5;    // register address width
  localparam int DW   = 32;   // data width
  localparam int CNTW = 16;   // stall counter width

  localparam logic [CNTW-1:0] STALL_MAX = '1;

  // Which write-back source feeds the port when the holding buffer is empty
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regbank_write_scheduler_if.sv
// Issue, write-back and register-bank write-port signals of the write scheduler.
interface regbank_write_scheduler_if;
  import regbank_write_scheduler_pkg::*;

  logic            issue_valid;
  logic [AW-1:0]   issue_rs;
  logic [AW-1:0]   issue_rt;
  logic [AW-1:0]   issue_rd;
  logic            issue_wr;
  logic            issue_ready;

  logic            alu_wb_valid;
  logic [AW-1:0]   alu_wb_rd;
  logic [DW-1:0]   alu_wb_data;
  logic            alu_wb_ready;

  logic            mem_wb_valid;
  logic [AW-1:0]   mem_wb_rd;
  logic [DW-1:0]   mem_wb_data;
  logic            mem_wb_ready;

  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [NREG-1:0] pending;
  logic [CNTW-1:0] stall_cnt;

  // Scheduler side
  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rd, issue_wr,
    output issue_ready,
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    output alu_wb_ready,
    input  mem_wb_valid, mem_wb_rd, mem_wb_data,
    output mem_wb_ready,
    output rf_we, rf_waddr, rf_wdata, pending, stall_cnt
  );

  // Decode / execute side
  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rd, issue_wr,
    input  issue_ready,
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  alu_wb_ready,
    output mem_wb_valid, mem_wb_rd, mem_wb_data,
    input  mem_wb_ready,
    input  rf_we, rf_waddr, rf_wdata, pending, stall_cnt
  );

endinterface

// File: rtl/regbank_write_scheduler_wb_hold_buffer.sv
// One-entry holding register for an ALU write-back that lost arbitration to MEM.
module wb_hold_buffer
  import regbank_write_scheduler_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          drain,
  input  logic [AW-1:0] load_rd,
  input  logic [DW-1:0] load_data,
  output logic          valid,
  output logic [AW-1:0] rd,
  output logic [DW-1:0] data
);

  logic          valid_reg;
  logic          valid_next;
  logic [AW-1:0] rd_reg;
  logic [DW-1:0] data_reg;

  // Occupancy: load only happens while empty, drain only while full
  always_comb begin
    valid_next = valid_reg;
    if (load) begin
      valid_next = 1'b1;
    end else if (drain) begin
      valid_next = 1'b0;
    end
  end

  // Entry storage; a reset discards whatever was held
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      rd_reg    <= '0;
      data_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      if (load) begin
        rd_reg   <= load_rd;
        data_reg <= load_data;
      end
    end
  end

  assign valid = valid_reg;
  assign rd    = rd_reg;
  assign data  = data_reg;

endmodule

// File: rtl/regbank_write_scheduler.sv
// Issue hazard scoreboard plus ALU/MEM write-back merge onto the single bank write port.
module regbank_write_scheduler
  import regbank_write_scheduler_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  regbank_write_scheduler_if.slave  bus
);

  logic [NREG-1:0] pending_reg;
  logic [NREG-1:0] pending_next;

  logic            issue_ready;
  logic            issue_fire;

  logic            buf_valid;
  logic [AW-1:0]   buf_rd;
  logic [DW-1:0]   buf_data;
  logic            buf_load;
  logic            buf_drain;

  wb_src_e         direct_src;
  logic            commit_valid;
  logic [AW-1:0]   commit_rd;
  logic [DW-1:0]   commit_data;
  logic            commit_write;

  logic            rf_we_reg;
  logic [AW-1:0]   rf_waddr_reg;
  logic [DW-1:0]   rf_wdata_reg;
  logic [CNTW-1:0] stall_cnt_reg;

  // Hazard check against the registered scoreboard only (no same-cycle bypass)
  always_comb begin
    issue_ready = ~pending_reg[bus.issue_rs] & ~pending_reg[bus.issue_rt] &
                  ~(bus.issue_wr & pending_reg[bus.issue_rd]);
  end

  assign issue_fire = bus.issue_valid & issue_ready;

  // Write-port arbitration: held ALU entry first, then MEM, then a lone ALU request
  always_comb begin
    commit_valid = 1'b0;
    buf_load     = 1'b0;
    buf_drain    = 1'b0;
    direct_src   = WB_ALU;
    commit_rd    = '0;
    commit_data  = '0;
    if (buf_valid) begin
      commit_valid = 1'b1;
      buf_drain    = 1'b1;
      commit_rd    = buf_rd;
      commit_data  = buf_data;
    end else begin
      if (bus.mem_wb_valid) begin
        direct_src   = WB_MEM;
        commit_valid = 1'b1;
        buf_load     = bus.alu_wb_valid;
      end else if (bus.alu_wb_valid) begin
        direct_src   = WB_ALU;
        commit_valid = 1'b1;
      end
      commit_rd   = (direct_src == WB_MEM) ? bus.mem_wb_rd   : bus.alu_wb_rd;
      commit_data = (direct_src == WB_MEM) ? bus.mem_wb_data : bus.alu_wb_data;
    end
  end

  // Both sources are accepted exactly when the holding buffer is empty
  assign bus.alu_wb_ready = ~buf_valid;
  assign bus.mem_wb_ready = ~buf_valid;

  // r0 writes complete the handshake but never reach the bank
  assign commit_write = commit_valid & (commit_rd != '0);

  wb_hold_buffer u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load),
    .drain     (buf_drain),
    .load_rd   (bus.alu_wb_rd),
    .load_data (bus.alu_wb_data),
    .valid     (buf_valid),
    .rd        (buf_rd),
    .data      (buf_data)
  );

  // Per-register scoreboard update; an issue set beats a commit clear on the same bit
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_bit
        assign pending_next[gi] =
          (issue_fire & bus.issue_wr & (bus.issue_rd == AW'(gi))) |
          (pending_reg[gi] & ~(commit_valid & (commit_rd == AW'(gi))));
      end
    end
  endgenerate

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // Registered bank write port; address/data hold between writes
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else begin
      rf_we_reg <= commit_write;
      if (commit_write) begin
        rf_waddr_reg <= commit_rd;
        rf_wdata_reg <= commit_data;
      end
    end
  end

  // Saturating count of cycles where decode waits on a hazard
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (bus.issue_valid && !issue_ready && (stall_cnt_reg != STALL_MAX)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.rf_we       = rf_we_reg;
  assign bus.rf_waddr    = rf_waddr_reg;
  assign bus.rf_wdata    = rf_wdata_reg;
  assign bus.pending     = pending_reg;
  assign bus.stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_regbank_write_scheduler.sv
// Directed plus randomized bench for the register-bank write scheduler.
module tb_regbank_write_scheduler;
  import regbank_write_scheduler_pkg::*;

  logic clk = 1'b0;
  logic reset;

  regbank_write_scheduler_if bus ();

  regbank_write_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit [NREG-1:0] m_pending;
  int            m_cnt;
  bit [AW-1:0]   m_hold_rd[$];
  bit [DW-1:0]   m_hold_data[$];
  bit            m_we;
  bit [AW-1:0]   m_waddr;
  bit [DW-1:0]   m_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.issue_valid  = 1'b0;
    bus.issue_rs     = '0;
    bus.issue_rt     = '0;
    bus.issue_rd     = '0;
    bus.issue_wr     = 1'b0;
    bus.alu_wb_valid = 1'b0;
    bus.alu_wb_rd    = '0;
    bus.alu_wb_data  = '0;
    bus.mem_wb_valid = 1'b0;
    bus.mem_wb_rd    = '0;
    bus.mem_wb_data  = '0;
  endtask

  task automatic set_issue(input bit v, input int rs, input int rt, input int rd, input bit wr);
    bus.issue_valid = v;
    bus.issue_rs    = AW'(rs);
    bus.issue_rt    = AW'(rt);
    bus.issue_rd    = AW'(rd);
    bus.issue_wr    = wr;
  endtask

  task automatic set_alu(input bit v, input int rd, input logic [DW-1:0] d);
    bus.alu_wb_valid = v;
    bus.alu_wb_rd    = AW'(rd);
    bus.alu_wb_data  = d;
  endtask

  task automatic set_mem(input bit v, input int rd, input logic [DW-1:0] d);
    bus.mem_wb_valid = v;
    bus.mem_wb_rd    = AW'(rd);
    bus.mem_wb_data  = d;
  endtask

  // Reset for one edge, then check every output against its reset value
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_pending = '0;
    m_cnt     = 0;
    m_hold_rd.delete();
    m_hold_data.delete();
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_waddr", bus.rf_waddr, 0);
    check("rst_rf_wdata", bus.rf_wdata, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_stall_cnt", bus.stall_cnt, 0);
    check("rst_alu_ready", bus.alu_wb_ready, 1);
    check("rst_mem_ready", bus.mem_wb_ready, 1);
  endtask

  // One clock: predict ready signals, advance the model, compare registered outputs
  task automatic cycle(input bit chk);
    bit            exp_wb_ready;
    bit            exp_issue_ready;
    bit            c_valid;
    bit [AW-1:0]   c_rd;
    bit [DW-1:0]   c_data;
    bit [NREG-1:0] set_v;
    bit [NREG-1:0] clr_v;
    @(negedge clk);
    exp_wb_ready    = (m_hold_rd.size() == 0);
    exp_issue_ready = !m_pending[bus.issue_rs] && !m_pending[bus.issue_rt] &&
                      !(bus.issue_wr && m_pending[bus.issue_rd]);
    if (chk) begin
      check("issue_ready", bus.issue_ready, exp_issue_ready);
      check("alu_wb_ready", bus.alu_wb_ready, exp_wb_ready);
      check("mem_wb_ready", bus.mem_wb_ready, exp_wb_ready);
    end
    set_v = '0;
    clr_v = '0;
    if (bus.issue_valid && !exp_issue_ready && m_cnt < 65535) m_cnt++;
    if (bus.issue_valid && exp_issue_ready && bus.issue_wr && bus.issue_rd != 0)
      set_v[bus.issue_rd] = 1'b1;
    c_valid = 1'b0;
    c_rd    = '0;
    c_data  = '0;
    if (m_hold_rd.size() != 0) begin
      c_valid = 1'b1;
      c_rd    = m_hold_rd.pop_front();
      c_data  = m_hold_data.pop_front();
    end else if (bus.mem_wb_valid) begin
      c_valid = 1'b1;
      c_rd    = bus.mem_wb_rd;
      c_data  = bus.mem_wb_data;
      if (bus.alu_wb_valid) begin
        m_hold_rd.push_back(bus.alu_wb_rd);
        m_hold_data.push_back(bus.alu_wb_data);
      end
    end else if (bus.alu_wb_valid) begin
      c_valid = 1'b1;
      c_rd    = bus.alu_wb_rd;
      c_data  = bus.alu_wb_data;
    end
    if (c_valid) clr_v[c_rd] = 1'b1;
    m_pending    = (m_pending & ~clr_v) | set_v;
    m_pending[0] = 1'b0;
    m_we = c_valid && (c_rd != 0);
    if (m_we) begin
      m_waddr = c_rd;
      m_wdata = c_data;
    end
    @(posedge clk);
    #1;
    if (chk) begin
      check("rf_we", bus.rf_we, m_we);
      if (m_we) begin
        check("rf_waddr", bus.rf_waddr, m_waddr);
        check("rf_wdata", bus.rf_wdata, m_wdata);
      end
      check("pending", bus.pending, m_pending);
      check("stall_cnt", bus.stall_cnt, m_cnt);
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Issue a writer of r5
    set_issue(1, 1, 2, 5, 1);
    cycle(1);
    check("t_pend5_set", bus.pending[5], 1);

    // Reader of r5 stalls, counter climbs
    set_issue(1, 5, 2, 7, 1);
    for (int i = 0; i < 3; i++) cycle(1);
    check("t_stall3", bus.stall_cnt, 3);

    // ALU write-back of r5 lands next cycle; stalled issue then goes through
    set_alu(1, 5, 32'h1234);
    cycle(1);
    check("t_alu_we", bus.rf_we, 1);
    check("t_alu_addr", bus.rf_waddr, 5);
    check("t_alu_data", bus.rf_wdata, 32'h1234);
    check("t_pend5_clr", bus.pending[5], 0);
    set_alu(0, 0, 0);
    cycle(1);
    check("t_pend7_set", bus.pending[7], 1);
    idle();
    cycle(1);

    // MEM r3 and ALU r4 collide; MEM holds its request while the buffer drains
    set_mem(1, 3, 32'hAAAA);
    set_alu(1, 4, 32'hBBBB);
    cycle(1);
    check("t_mem_addr", bus.rf_waddr, 3);
    check("t_mem_data", bus.rf_wdata, 32'hAAAA);
    set_alu(0, 0, 0);
    set_mem(1, 6, 32'hCCCC);
    cycle(1);
    check("t_buf_addr", bus.rf_waddr, 4);
    check("t_buf_data", bus.rf_wdata, 32'hBBBB);
    cycle(1);
    check("t_mem2_addr", bus.rf_waddr, 6);
    idle();
    cycle(1);

    // r0 destinations: no scoreboard bit, no bank write, handshake still taken
    set_issue(1, 0, 0, 0, 1);
    set_alu(1, 0, 32'hDEAD);
    cycle(1);
    check("t_r0_pend0", bus.pending[0], 0);
    check("t_r0_we", bus.rf_we, 0);
    idle();
    cycle(1);

    // Randomized traffic over a small register window for frequent hazards
    for (int i = 0; i < 400; i++) begin
      set_issue($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 1) != 0);
      set_alu($urandom_range(0, 1) != 0, $urandom_range(0, 7), $urandom);
      set_mem($urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom);
      cycle(1);
    end
    idle();

    // Stall counter saturation
    do_reset();
    set_issue(1, 0, 0, 9, 1);
    cycle(1);
    set_issue(1, 9, 0, 0, 0);
    for (int i = 0; i < 65546; i++) cycle(0);
    cycle(1);
    check("t_stall_sat", bus.stall_cnt, 16'hFFFF);
    set_issue(0, 0, 0, 0, 0);
    set_alu(1, 9, 32'h9);
    cycle(1);
    idle();
    cycle(1);

    // Reset while the buffer is full and r4/r5 are pending
    set_issue(1, 0, 0, 4, 1);
    cycle(1);
    set_issue(1, 0, 0, 5, 1);
    cycle(1);
    idle();
    set_mem(1, 1, 32'h11);
    set_alu(1, 2, 32'h22);
    cycle(1);
    check("t_pend_30", bus.pending, 64'h30);
    check("t_buf_full", bus.alu_wb_ready, 0);
    idle();
    do_reset();
    cycle(1);
    check("t_post_rst_we", bus.rf_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
